// File: rtl/ring_pkg.sv
// Shared definitions for the parametrised ring/Johnson counter.
package ring_pkg;

    typedef enum logic {
        MODE_RING    = 1'b0,
        MODE_JOHNSON = 1'b1
    } ring_mode_e;

    // Number of distinct indices visited in the given mode.
    function automatic int states(input logic mode, input int n);
        return (mode == MODE_JOHNSON) ? 2 * n : n;
    endfunction

endpackage

// File: rtl/ring_decode.sv
// Combinational index-to-pattern decode for one-hot ring and Johnson modes.
module ring_decode
    import ring_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(2 * N)
) (
    input  logic [IW-1:0] idx,
    input  logic          mode,
    output logic [N-1:0]  f
);

    int unsigned k;
    int unsigned n_u;

    // Johnson first half fills ones from bit 0; second half clears them from bit 0.
    always_comb begin
        f   = '0;
        k   = int'(idx);
        n_u = N;
        for (int unsigned i = 0; i < n_u; i++) begin
            if (mode == MODE_RING)
                f[i] = (k == i);
            else if (k <= n_u)
                f[i] = (i < k);
            else
                f[i] = (i >= k - n_u);
        end
    end

endmodule

// File: rtl/ring_counter_n.sv
// N-bit ring/Johnson sequencer with direction, index load, wrap pulse and load-error pulse.
module ring_counter_n
    import ring_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(2 * N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          dir,
    input  logic          mode,
    input  logic          load,
    input  logic [IW-1:0] load_idx,
    output logic [N-1:0]  f,
    output logic [IW-1:0] idx_o,
    output logic          tc,
    output logic          err
);

    ring_mode_e    mode_q, mode_n;
    logic [IW-1:0] idx_q, idx_n, last;
    logic [N-1:0]  f_n;
    logic          tc_n, err_n;
    int            m;

    always_comb begin
        m      = states(mode_q, N);
        last   = IW'(m - 1);
        idx_n  = idx_q;
        mode_n = mode_q;
        tc_n   = 1'b0;
        err_n  = 1'b0;
        if (ring_mode_e'(mode) != mode_q) begin
            mode_n = ring_mode_e'(mode);
            idx_n  = '0;
        end else if (load) begin
            if (int'(load_idx) < m) begin
                idx_n = load_idx;
            end else begin
                idx_n = '0;
                err_n = 1'b1;
            end
        end else if (en) begin
            if (!dir) begin
                if (idx_q == last) begin
                    idx_n = '0;
                    tc_n  = 1'b1;
                end else begin
                    idx_n = idx_q + IW'(1);
                end
            end else begin
                if (idx_q == '0) begin
                    idx_n = last;
                    tc_n  = 1'b1;
                end else begin
                    idx_n = idx_q - IW'(1);
                end
            end
        end
    end

    // Decoding the next-state index keeps f aligned with idx_o without an extra stage.
    ring_decode #(
        .N  (N),
        .IW (IW)
    ) u_decode (
        .idx  (idx_n),
        .mode (mode_n),
        .f    (f_n)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q  <= '0;
            mode_q <= MODE_RING;
            f      <= {{(N-1){1'b0}}, 1'b1};
            tc     <= 1'b0;
            err    <= 1'b0;
        end else begin
            idx_q  <= idx_n;
            mode_q <= mode_n;
            f      <= f_n;
            tc     <= tc_n;
            err    <= err_n;
        end
    end

    assign idx_o = idx_q;

endmodule

// File: tb/tb_ring_counter_n.sv
// Scoreboard bench for ring_counter_n (N=4): directed vectors queue expectations, a monitor checks them.
module tb_ring_counter_n;

    localparam int N  = 4;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n, en, dir, mode, load;
    logic [IW-1:0] load_idx;
    logic [N-1:0]  f;
    logic [IW-1:0] idx_o;
    logic          tc, err;

    typedef struct {
        string         name;
        logic [N-1:0]  f;
        logic [IW-1:0] idx;
        logic          tc;
        logic          err;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   checks = 0;
    int   fails  = 0;

    ring_counter_n #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_idx (load_idx),
        .f        (f),
        .idx_o    (idx_o),
        .tc       (tc),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
            checks++;
            if (f !== cur.f || idx_o !== cur.idx || tc !== cur.tc || err !== cur.err) begin
                fails++;
                $display("FAIL %s: got f=%b idx=%0d tc=%b err=%b, expected f=%b idx=%0d tc=%b err=%b",
                         cur.name, f, idx_o, tc, err, cur.f, cur.idx, cur.tc, cur.err);
            end
        end
    end

    task automatic step(input string nm, input logic r, input logic e, input logic d,
                        input logic m, input logic l, input logic [IW-1:0] li,
                        input logic [N-1:0] ef, input logic [IW-1:0] ei,
                        input logic et, input logic ee);
        exp_t x;
        rst_n = r; en = e; dir = d; mode = m; load = l; load_idx = li;
        @(posedge clk);
        #1;
        x.name = nm; x.f = ef; x.idx = ei; x.tc = et; x.err = ee;
        q.push_back(x);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_idx = '0;
        //      name            rst en dir mode ld lidx  f        idx tc err
        step("reset",          0, 0, 0, 0, 0, 3'd0, 4'b0001, 3'd0, 0, 0);
        step("ring_up1",       1, 1, 0, 0, 0, 3'd0, 4'b0010, 3'd1, 0, 0);
        step("ring_up2",       1, 1, 0, 0, 0, 3'd0, 4'b0100, 3'd2, 0, 0);
        step("ring_up3",       1, 1, 0, 0, 0, 3'd0, 4'b1000, 3'd3, 0, 0);
        step("ring_wrap",      1, 1, 0, 0, 0, 3'd0, 4'b0001, 3'd0, 1, 0);
        step("ring_up_after",  1, 1, 0, 0, 0, 3'd0, 4'b0010, 3'd1, 0, 0);
        step("ring_hold",      1, 0, 0, 0, 0, 3'd0, 4'b0010, 3'd1, 0, 0);
        step("ring_dn1",       1, 1, 1, 0, 0, 3'd0, 4'b0001, 3'd0, 0, 0);
        step("ring_dn_wrap",   1, 1, 1, 0, 0, 3'd0, 4'b1000, 3'd3, 1, 0);
        step("ring_dn2",       1, 1, 1, 0, 0, 3'd0, 4'b0100, 3'd2, 0, 0);
        step("ring_load1",     1, 1, 0, 0, 1, 3'd1, 4'b0010, 3'd1, 0, 0);
        step("ring_load2_en",  1, 1, 0, 0, 1, 3'd2, 4'b0100, 3'd2, 0, 0);
        step("ring_load_bad",  1, 1, 0, 0, 1, 3'd5, 4'b0001, 3'd0, 0, 1);
        step("err_clears",     1, 0, 0, 0, 0, 3'd0, 4'b0001, 3'd0, 0, 0);
        step("to_johnson",     1, 1, 0, 1, 1, 3'd3, 4'b0000, 3'd0, 0, 0);
        step("j_up1",          1, 1, 0, 1, 0, 3'd0, 4'b0001, 3'd1, 0, 0);
        step("j_up2",          1, 1, 0, 1, 0, 3'd0, 4'b0011, 3'd2, 0, 0);
        step("j_up3",          1, 1, 0, 1, 0, 3'd0, 4'b0111, 3'd3, 0, 0);
        step("j_up4",          1, 1, 0, 1, 0, 3'd0, 4'b1111, 3'd4, 0, 0);
        step("j_up5",          1, 1, 0, 1, 0, 3'd0, 4'b1110, 3'd5, 0, 0);
        step("j_up6",          1, 1, 0, 1, 0, 3'd0, 4'b1100, 3'd6, 0, 0);
        step("j_up7",          1, 1, 0, 1, 0, 3'd0, 4'b1000, 3'd7, 0, 0);
        step("j_wrap",         1, 1, 0, 1, 0, 3'd0, 4'b0000, 3'd0, 1, 0);
        step("j_load5",        1, 0, 0, 1, 1, 3'd5, 4'b1110, 3'd5, 0, 0);
        step("j_load7",        1, 0, 0, 1, 1, 3'd7, 4'b1000, 3'd7, 0, 0);
        step("j_dn",           1, 1, 1, 1, 0, 3'd0, 4'b1100, 3'd6, 0, 0);
        step("j_load0",        1, 0, 0, 1, 1, 3'd0, 4'b0000, 3'd0, 0, 0);
        step("j_dn_wrap",      1, 1, 1, 1, 0, 3'd0, 4'b1000, 3'd7, 1, 0);
        step("j_dn_to6",       1, 1, 1, 1, 0, 3'd0, 4'b1100, 3'd6, 0, 0);
        step("reset_mid",      0, 1, 0, 1, 1, 3'd2, 4'b0001, 3'd0, 0, 0);
        step("ring_after_rst", 1, 0, 0, 0, 0, 3'd0, 4'b0001, 3'd0, 0, 0);
        step("ring_load2",     1, 0, 0, 0, 1, 3'd2, 4'b0100, 3'd2, 0, 0);
        step("mode_beats_ld",  1, 1, 0, 1, 1, 3'd1, 4'b0000, 3'd0, 0, 0);
        step("mode_back_ring", 1, 1, 0, 0, 1, 3'd7, 4'b0001, 3'd0, 0, 0);

        en = 1'b0; load = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
